// File: rtl/rom_axil_bram_loader_if.sv
// AXI4-Lite slave channel bundle for the ROM loader: AW, W, B, AR, R.
interface rom_axil_bram_loader_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/rom_axil_bram_loader.sv
// AXI4-Lite slave that loads (and optionally reads back) a BRAM-backed ROM image.
// Define FPGA_ROM_READBACK_EN to enable BRAM reads; otherwise reads answer SLVERR with zero data.
module rom_axil_bram_loader #(
  parameter int unsigned ROM_BYTES = 65536
) (
  input  logic                   axi_bram_clk,
  input  logic                   axi_bram_rst,
  rom_axil_bram_loader_if.slave  s_axil,
  output logic                   axi_bram_en,
  output logic [3:0]             axi_bram_we,
  output logic [15:0]            axi_bram_addr,
  output logic [31:0]            axi_bram_din,
  input  logic [31:0]            axi_bram_dout
);

  localparam int unsigned BRAM_AW   = 16;
  localparam logic [31:0] ROM_LIMIT = 32'(ROM_BYTES);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEM,
    WR_RESP,
`ifdef FPGA_ROM_READBACK_EN
    RD_MEM,
    RD_CAP,
`endif
    RD_RESP
  } state_t;

  state_t             state;
  logic               wr_first;
  logic               req_oor;

  logic               wr_req_c;
  logic               rd_req_c;
  logic               grant_wr_c;
  logic               grant_rd_c;
  logic               can_grant_c;
  logic               wr_oor_c;
  logic [BRAM_AW-1:0] wr_addr_c;

  assign wr_req_c   = s_axil.awvalid & s_axil.wvalid;
  assign rd_req_c   = s_axil.arvalid;
  assign grant_wr_c = wr_req_c & (~rd_req_c | wr_first);
  assign grant_rd_c = rd_req_c & ~grant_wr_c;
  assign wr_oor_c   = (s_axil.awaddr >= ROM_LIMIT);
  assign wr_addr_c  = {s_axil.awaddr[BRAM_AW-1:2], 2'b00};

`ifdef FPGA_ROM_READBACK_EN
  logic               rd_oor_c;
  logic [BRAM_AW-1:0] rd_addr_c;

  assign rd_oor_c  = (s_axil.araddr >= ROM_LIMIT);
  assign rd_addr_c = {s_axil.araddr[BRAM_AW-1:2], 2'b00};
`else
  // Read data path is not built; fold the idle inputs into a sink.
  logic unused_rd_c;
  assign unused_rd_c = ^{axi_bram_dout, s_axil.araddr};
`endif

  // A new grant may be issued from an idle slot or on the edge a response is accepted.
  always_comb begin
    can_grant_c = 1'b0;
    case (state)
      IDLE:    can_grant_c = ~s_axil.awready & ~s_axil.arready;
      WR_RESP: can_grant_c = s_axil.bready;
      RD_RESP: can_grant_c = s_axil.rready;
      default: can_grant_c = 1'b0;
    endcase
  end

  always_ff @(posedge axi_bram_clk or posedge axi_bram_rst) begin
    if (axi_bram_rst) begin
      state          <= IDLE;
      wr_first       <= 1'b1;
      req_oor        <= 1'b0;
      s_axil.awready <= 1'b0;
      s_axil.wready  <= 1'b0;
      s_axil.arready <= 1'b0;
      s_axil.bvalid  <= 1'b0;
      s_axil.bresp   <= 2'b00;
      s_axil.rvalid  <= 1'b0;
      s_axil.rresp   <= 2'b00;
      s_axil.rdata   <= '0;
      axi_bram_en    <= 1'b0;
      axi_bram_we    <= 4'h0;
      axi_bram_addr  <= '0;
      axi_bram_din   <= '0;
    end else begin
      s_axil.awready <= 1'b0;
      s_axil.wready  <= 1'b0;
      s_axil.arready <= 1'b0;
      axi_bram_en    <= 1'b0;
      axi_bram_we    <= 4'h0;

      case (state)
        // Ready is high during the handshake cycle; commit the transfer at its closing edge.
        IDLE: begin
          if (s_axil.awready) begin
            req_oor <= wr_oor_c;
            state   <= WR_MEM;
            if (!wr_oor_c) begin
              axi_bram_en   <= 1'b1;
              axi_bram_we   <= s_axil.wstrb;
              axi_bram_addr <= wr_addr_c;
              axi_bram_din  <= s_axil.wdata;
            end
          end else if (s_axil.arready) begin
`ifdef FPGA_ROM_READBACK_EN
            req_oor <= rd_oor_c;
            state   <= RD_MEM;
            if (!rd_oor_c) begin
              axi_bram_en   <= 1'b1;
              axi_bram_addr <= rd_addr_c;
            end
`else
            s_axil.rvalid <= 1'b1;
            s_axil.rdata  <= '0;
            s_axil.rresp  <= RESP_SLVERR;
            state         <= RD_RESP;
`endif
          end
        end

        WR_MEM: begin
          s_axil.bvalid <= 1'b1;
          s_axil.bresp  <= req_oor ? RESP_SLVERR : RESP_OKAY;
          state         <= WR_RESP;
        end

        WR_RESP: begin
          if (s_axil.bready) begin
            s_axil.bvalid <= 1'b0;
            state         <= IDLE;
          end
        end

`ifdef FPGA_ROM_READBACK_EN
        RD_MEM: begin
          state <= RD_CAP;
        end

        // BRAM output is valid one cycle after en.
        RD_CAP: begin
          s_axil.rvalid <= 1'b1;
          s_axil.rdata  <= req_oor ? 32'h0 : axi_bram_dout;
          s_axil.rresp  <= req_oor ? RESP_SLVERR : RESP_OKAY;
          state         <= RD_RESP;
        end
`endif

        RD_RESP: begin
          if (s_axil.rready) begin
            s_axil.rvalid <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Round-robin: the side not granted last wins a tie.
      if (can_grant_c) begin
        if (grant_wr_c) begin
          s_axil.awready <= 1'b1;
          s_axil.wready  <= 1'b1;
          wr_first       <= 1'b0;
        end else if (grant_rd_c) begin
          s_axil.arready <= 1'b1;
          wr_first       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_axil_bram_loader.sv
// Self-checking bench for rom_axil_bram_loader: directed vectors, corner sequences, random traffic.
module tb_rom_axil_bram_loader;

  localparam int unsigned ROM     = 65536;
  localparam logic [31:0] ROM_LIM = 32'(ROM);
`ifdef FPGA_ROM_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif
  localparam int RD_LAT = READBACK ? 3 : 1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rom_axil_bram_loader_if bus ();

  logic        en;
  logic [3:0]  we;
  logic [15:0] baddr;
  logic [31:0] din;
  logic [31:0] dout;

  rom_axil_bram_loader #(.ROM_BYTES(ROM)) dut (
    .axi_bram_clk  (clk),
    .axi_bram_rst  (rst),
    .s_axil        (bus),
    .axi_bram_en   (en),
    .axi_bram_we   (we),
    .axi_bram_addr (baddr),
    .axi_bram_din  (din),
    .axi_bram_dout (dout)
  );

  // Simple byte-enable BRAM, read-first, one cycle latency.
  logic [31:0] bram [16384] = '{default: '0};
  always @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) bram[baddr[15:2]][8*b +: 8] <= din[8*b +: 8];
      dout <= bram[baddr[15:2]];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Transaction-level reference: word array with byte strobes and the range rule.
  logic [31:0] ref_mem [16384] = '{default: '0};

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    if (a >= ROM_LIM) return SLVERR;
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[15:2]][8*b +: 8] = d[8*b +: 8];
    return OKAY;
  endfunction

  function automatic void model_read(input logic [31:0] a, output logic [1:0] r,
                                     output logic [31:0] d);
    if (!READBACK || a >= ROM_LIM) begin
      r = SLVERR;
      d = 32'h0;
    end else begin
      r = OKAY;
      d = ref_mem[a[15:2]];
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                               bus.bresp, bus.rresp, en, we}), 32'h0);
    check({tag, "_rdata"}, bus.rdata, 32'h0);
    check({tag, "_bram_addr"}, 32'(baddr), 32'h0);
    check({tag, "_bram_din"}, din, 32'h0);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdly, output logic [1:0] resp);
    int n;
    bit in_rng;
    bit stable;
    logic [1:0] held;
    in_rng = (a < ROM_LIM);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.awready && n < 20) begin @(negedge clk); n++; end
    check("wr_accept", 32'({bus.awready, bus.wready}), 32'h3);
    if (!bus.awready) begin
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; resp = 2'b11;
      return;
    end
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("wr_ready_drop", 32'({bus.awready, bus.wready}), 32'h0);
    check("wr_en", 32'(en), 32'(in_rng));
    check("wr_we", 32'(we), in_rng ? 32'(s) : 32'h0);
    if (in_rng) begin
      check("wr_addr", 32'(baddr), {16'h0, a[15:2], 2'b00});
      check("wr_din", din, d);
    end
    n = 1;
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    check("wr_lat", 32'(n), 32'd2);
    check("wr_en_off", 32'({en, we}), 32'h0);
    held = bus.bresp; stable = 1'b1;
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      if (!bus.bvalid || bus.bresp !== held) stable = 1'b0;
    end
    if (bdly > 0) check("wr_bhold", 32'(stable), 32'h1);
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("wr_bdone", 32'(bus.bvalid), 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdly, output logic [1:0] resp,
                          output logic [31:0] data);
    int n;
    bit in_rng;
    bit stable;
    logic [31:0] held_d;
    logic [1:0] held_r;
    in_rng = (a < ROM_LIM);
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    check("rd_accept", 32'(bus.arready), 32'h1);
    if (!bus.arready) begin
      bus.arvalid = 1'b0; resp = 2'b11; data = 32'hx;
      return;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rd_ready_drop", 32'(bus.arready), 32'h0);
    check("rd_en", 32'(en), 32'(READBACK && in_rng));
    check("rd_we", 32'(we), 32'h0);
    if (READBACK && in_rng) check("rd_addr", 32'(baddr), {16'h0, a[15:2], 2'b00});
    n = 1;
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    check("rd_lat", 32'(n), 32'(RD_LAT));
    check("rd_en_off", 32'(en), 32'h0);
    held_d = bus.rdata; held_r = bus.rresp; stable = 1'b1;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      if (!bus.rvalid || bus.rdata !== held_d || bus.rresp !== held_r) stable = 1'b0;
    end
    if (rdly > 0) check("rd_hold", 32'(stable), 32'h1);
    resp = bus.rresp;
    data = bus.rdata;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("rd_rdone", 32'(bus.rvalid), 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 check_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [16];
  logic [1:0]  resp, exp_r;
  logic [31:0] data, exp_d, a, d;
  logic [3:0]  s;
  int          dly;
  bit          saw;
  int          wr_left, rd_left, k;
  bit          wr_hs, rd_hs;
  int          order [4];
  int          when [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rd    addr          data          strb  resp    rdata (with readback)
    vecs[0]  = '{1'b0, 32'h0000_0104, 32'hDEADBEEF, 4'hF, OKAY,   32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0104, 32'h0,        4'h0, OKAY,   32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h0001_0000, 32'hCAFEF00D, 4'hF, SLVERR, 32'h0};
    vecs[3]  = '{1'b1, 32'h0001_0000, 32'h0,        4'h0, SLVERR, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0200, 32'h11223344, 4'h3, OKAY,   32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0200, 32'h0,        4'h0, OKAY,   32'h00003344};
    vecs[6]  = '{1'b0, 32'h0000_FFFC, 32'hA5A5A5A5, 4'hF, OKAY,   32'h0};
    vecs[7]  = '{1'b1, 32'h0000_FFFC, 32'h0,        4'h0, OKAY,   32'hA5A5A5A5};
    vecs[8]  = '{1'b0, 32'h0000_0106, 32'h12345678, 4'hF, OKAY,   32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0104, 32'h0,        4'h0, OKAY,   32'h12345678};
    vecs[10] = '{1'b0, 32'h0000_0104, 32'hFFFFFFFF, 4'h0, OKAY,   32'h0};
    vecs[11] = '{1'b1, 32'h0000_0104, 32'h0,        4'h0, OKAY,   32'h12345678};
    vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h00000001, 4'hF, SLVERR, 32'h0};
    vecs[13] = '{1'b1, 32'h0000_FFFF, 32'h0,        4'h0, OKAY,   32'hA5A5A5A5};
    vecs[14] = '{1'b0, 32'h0000_0200, 32'hAABBCCDD, 4'hC, OKAY,   32'h0};
    vecs[15] = '{1'b1, 32'h0000_0200, 32'h0,        4'h0, OKAY,   32'hAABB3344};

    bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;

    // Reset: outputs cleared immediately, no ready while held.
    #2 rst = 1'b1;
    #1 check_all_zero("por");
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.awready || bus.wready || bus.arready) saw = 1'b1;
    end
    check("rst_no_ready", 32'(saw), 32'h0);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_rd) begin
        axi_read(vecs[i].addr, i % 3, resp, data);
        exp_r = READBACK ? vecs[i].exp_resp : SLVERR;
        exp_d = READBACK ? vecs[i].exp_rdata : 32'h0;
        check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(exp_r));
        check($sformatf("vec%0d_rdata", i), data, exp_d);
      end else begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, resp);
        void'(model_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
        check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end
    end

    // AW alone must not be accepted until W joins.
    bus.awaddr = 32'h0000_0400; bus.awvalid = 1'b1; bus.wvalid = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.awready || bus.wready) saw = 1'b1;
    end
    check("aw_alone_no_ready", 32'(saw), 32'h0);
    axi_write(32'h0000_0400, 32'h5A5A0400, 4'hF, 0, resp);
    check("aw_alone_bresp", 32'(resp), 32'(model_write(32'h0000_0400, 32'h5A5A0400, 4'hF)));

    // Read with rready held low 5 cycles.
    axi_write(32'h0000_0104, 32'hDEADBEEF, 4'hF, 0, resp);
    check("hold_wr_bresp", 32'(resp), 32'(model_write(32'h0000_0104, 32'hDEADBEEF, 4'hF)));
    axi_read(32'h0000_0104, 5, resp, data);
    model_read(32'h0000_0104, exp_r, exp_d);
    check("hold_rresp", 32'(resp), 32'(exp_r));
    check("hold_rdata", data, exp_d);

    // Coinciding write and read, twice: round-robin from reset, back-to-back grants.
    apply_reset();
    bus.awaddr = 32'h0000_0300; bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF;
    bus.araddr = 32'h0000_0300;
    bus.bready = 1'b1; bus.rready = 1'b1;
    wr_left = 2; rd_left = 2; wr_hs = 1'b0; rd_hs = 1'b0; k = 0;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    for (int c = 0; c < 80 && k < 4; c++) begin
      @(negedge clk);
      if (wr_hs) begin wr_left--; wr_hs = 1'b0; end
      if (rd_hs) begin rd_left--; rd_hs = 1'b0; end
      bus.awvalid = (wr_left > 0); bus.wvalid = (wr_left > 0); bus.arvalid = (rd_left > 0);
      if (bus.awready) begin order[k] = 0; when[k] = c; k++; wr_hs = 1'b1; end
      else if (bus.arready) begin order[k] = 1; when[k] = c; k++; rd_hs = 1'b1; end
    end
    check("arb_grants", 32'(k), 32'd4);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    repeat (6) @(negedge clk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    if (k == 4) begin
      check("arb_order0", 32'(order[0]), 32'd0);
      check("arb_order1", 32'(order[1]), 32'd1);
      check("arb_order2", 32'(order[2]), 32'd0);
      check("arb_order3", 32'(order[3]), 32'd1);
      check("arb_gap_wr", 32'(when[1] - when[0]), 32'd3);
      check("arb_gap_rd", 32'(when[2] - when[1]), 32'(RD_LAT + 1));
    end
    void'(model_write(32'h0000_0300, 32'h0BADF00D, 4'hF));
    void'(model_write(32'h0000_0300, 32'h0BADF00D, 4'hF));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = 32'h0001_0000 + 32'($urandom_range(0, 255));
      else a = 32'h0000_1000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      dly = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        axi_read(a, dly, resp, data);
        model_read(a, exp_r, exp_d);
        check($sformatf("rnd%0d_rresp", i), 32'(resp), 32'(exp_r));
        check($sformatf("rnd%0d_rdata", i), data, exp_d);
      end else begin
        axi_write(a, d, s, dly, resp);
        check($sformatf("rnd%0d_bresp", i), 32'(resp), 32'(model_write(a, d, s)));
      end
    end

    // Reset mid-read: outputs clear at once, the read is dropped, next write is normal.
    bus.araddr = 32'h0000_0104; bus.arvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.arready && k < 20) begin @(negedge clk); k++; end
    check("mid_rst_accept", 32'(bus.arready), 32'h1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    repeat (READBACK ? 1 : 0) @(negedge clk);
    rst = 1'b1;
    #1 check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rvalid) saw = 1'b1;
    end
    check("mid_rst_no_rvalid", 32'(saw), 32'h0);
    axi_write(32'h0000_0500, 32'h600DCAFE, 4'hF, 0, resp);
    check("mid_rst_next_wr", 32'(resp), 32'(model_write(32'h0000_0500, 32'h600DCAFE, 4'hF)));
    axi_read(32'h0000_0500, 0, resp, data);
    model_read(32'h0000_0500, exp_r, exp_d);
    check("mid_rst_rd_resp", 32'(resp), 32'(exp_r));
    check("mid_rst_rd_data", data, exp_d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
